// File: rtl/shared_reg_if.sv
// Bundle between the requesting writers (master) and the shared-register arbiter (slave).
// Writers drive request/last/data lanes; the arbiter returns grant, owner and the register itself.
interface shared_reg_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int OWN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        last;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [OWN_W-1:0]          owner;
    logic                      busy;
    logic [DATA_W-1:0]         shared_q;
    logic                      wr_pulse;

    modport master (
        output req, last, wdata,
        input  gnt, owner, busy, shared_q, wr_pulse
    );

    modport slave (
        input  req, last, wdata,
        output gnt, owner, busy, shared_q, wr_pulse
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter giving NUM_REQ writers exclusive, burst-limited access to one register,
// with a dead turnaround cycle after every grant release.
module shared_reg_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    shared_reg_if.slave bus
);
    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_TURN
    } state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [OWN_W-1:0]   owner_q;
    logic [OWN_W-1:0]   rr_ptr_q;
    logic [OWN_W-1:0]   rr_ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q;
    logic [DATA_W-1:0]  shared_data_q;
    logic               wr_pulse_q;

    logic               sel_vld;
    logic [OWN_W-1:0]   sel_idx;
    logic               own_req;
    logic               own_last;
    logic               hold_done;
    logic [DATA_W-1:0]  own_data;

    // First requester at or after rr_ptr, wrapping past NUM_REQ-1 back to 0.
    always_comb begin : sel_scan
        int               idx;
        logic [OWN_W-1:0] cand;
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        sel_vld = 1'b0;
        sel_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = OWN_W'(idx);
            if (!sel_vld && bus.req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign own_req   = bus.req[owner_q];
    assign own_last  = bus.last[owner_q];
    assign own_data  = bus.wdata[int'(owner_q)*DATA_W +: DATA_W];
    assign hold_done = (hold_cnt_q == HOLD_LIM);
    assign rr_ptr_d  = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    // NOTE: all state, including the data register, is reset so a reset mid-burst leaves nothing partial.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
            shared_data_q <= '0;
            wr_pulse_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_TURN: begin
                    wr_pulse_q <= 1'b0;
                    hold_cnt_q <= '0;
                    if (sel_vld) begin
                        gnt_q   <= NUM_REQ'(1) << sel_idx;
                        owner_q <= sel_idx;
                        state_q <= ST_GRANT;
                    end else begin
                        gnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (own_req) begin
                        shared_data_q <= own_data;
                        wr_pulse_q    <= 1'b1;
                        hold_cnt_q    <= hold_cnt_q + 1'b1;
                    end else begin
                        wr_pulse_q    <= 1'b0;
                    end
                    // A dropped request, a final write or the hold limit all end the grant.
                    if (!own_req || own_last || hold_done) begin
                        gnt_q    <= '0;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ST_TURN;
                    end
                end
                default: begin
                    gnt_q      <= '0;
                    wr_pulse_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.shared_q = shared_data_q;
    assign bus.wr_pulse = wr_pulse_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: a transaction-level model checked every cycle,
// plus hand-computed expectations for reset, single write, round robin, hold limit and drops.
module tb_shared_reg_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;
    localparam int OWN_W    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    shared_reg_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    shared_reg_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: either someone holds the register (m_on) or the arbiter is free; a release
    // costs one dead cycle (m_turn); a free arbiter grants the first requester from m_ptr.
    bit          m_on;
    bit          m_turn;
    bit          m_pulse;
    int          m_own;
    int          m_cnt;
    int          m_ptr;
    logic [7:0]  m_shared;

    function automatic int pick(input int ptr, input logic [NUM_REQ-1:0] r);
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (ptr + k) % NUM_REQ;
            if (r[OWN_W'(i)]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_on <= 1'b0; m_turn <= 1'b0; m_pulse <= 1'b0;
            m_own <= 0; m_cnt <= 0; m_ptr <= 0; m_shared <= '0;
        end else if (m_on) begin
            if (bus.req[OWN_W'(m_own)]) begin
                m_shared <= bus.wdata[m_own*DATA_W +: DATA_W];
                m_pulse  <= 1'b1;
                m_cnt    <= m_cnt + 1;
            end else begin
                m_pulse  <= 1'b0;
            end
            if (!bus.req[OWN_W'(m_own)] || bus.last[OWN_W'(m_own)] || (m_cnt + 1 == MAX_HOLD)) begin
                m_on   <= 1'b0;
                m_turn <= 1'b1;
                m_ptr  <= (m_own + 1) % NUM_REQ;
            end
        end else begin
            m_pulse <= 1'b0;
            m_turn  <= 1'b0;
            if (bus.req != '0) begin
                m_on  <= 1'b1;
                m_own <= pick(m_ptr, bus.req);
                m_cnt <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cmp_gnt",   32'(bus.gnt),      m_on ? (32'd1 << m_own) : 32'd0);
            check("cmp_owner", 32'(bus.owner),    32'(m_own));
            check("cmp_busy",  32'(bus.busy),     32'(m_on | m_turn));
            check("cmp_data",  32'(bus.shared_q), 32'(m_shared));
            check("cmp_pulse", 32'(bus.wr_pulse), 32'(m_pulse));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] v);
        bus.wdata[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic do_reset();
        bus.req  = '0;
        bus.last = '0;
        rst_n    = 1'b0;
        #2;
        rst_n    = 1'b1;
        step();
    endtask

    int         exp_own[5]  = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g4[4]   = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};

    initial begin
        bus.req   = '0;
        bus.last  = '0;
        bus.wdata = '0;

        // Reset values while rst_n is held low from time zero.
        #7;
        check("rst_gnt",   32'(bus.gnt),      32'h0);
        check("rst_owner", 32'(bus.owner),    32'h0);
        check("rst_busy",  32'(bus.busy),     32'h0);
        check("rst_data",  32'(bus.shared_q), 32'h00);
        check("rst_pulse", 32'(bus.wr_pulse), 32'h0);
        #5 rst_n = 1'b1;
        step();

        // Single writer on lane 2 with last.
        bus.req = 4'b0100; bus.last = 4'b0100; set_lane(2, 8'hA5);
        step();
        check("single_gnt",   32'(bus.gnt),   32'h4);
        check("single_owner", 32'(bus.owner), 32'd2);
        step();
        check("single_data",  32'(bus.shared_q), 32'hA5);
        check("single_pulse", 32'(bus.wr_pulse), 32'h1);
        check("single_rel",   32'(bus.gnt),      32'h0);
        check("single_turn",  32'(bus.busy),     32'h1);
        bus.req = '0; bus.last = '0;
        step();
        check("single_idle",  32'(bus.busy),     32'h0);

        // Round robin with everyone requesting single-write bursts.
        do_reset();
        bus.req = 4'b1111; bus.last = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 8'h10 + 8'(i));
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_gnt",   32'(bus.gnt),   32'd1 << exp_own[k]);
            check("rr_owner", 32'(bus.owner), 32'(exp_own[k]));
            step();
            check("rr_turn",  32'(bus.gnt),      32'h0);
            check("rr_data",  32'(bus.shared_q), 32'h10 + 32'(exp_own[k]));
        end
        bus.req = '0; bus.last = '0;
        step();
        check("rr_idle", 32'(bus.busy), 32'h0);

        // Hold limit: owner 0 never signals last and is cut off after four writes.
        do_reset();
        bus.req = 4'b0011; bus.last = 4'b0010; set_lane(0, 8'h00); set_lane(1, 8'h77);
        step();
        check("hold_gnt0", 32'(bus.gnt), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            set_lane(0, 8'(i));
            step();
            check("hold_data",  32'(bus.shared_q), 32'(i));
            check("hold_pulse", 32'(bus.wr_pulse), 32'h1);
            check("hold_gnt",   32'(bus.gnt),      32'(exp_g4[i-1]));
        end
        set_lane(0, 8'h05);
        step();
        check("hold_next_gnt",  32'(bus.gnt),      32'h2);
        check("hold_no_5th",    32'(bus.shared_q), 32'h04);
        step();
        check("hold_next_data", 32'(bus.shared_q), 32'h77);
        bus.req = '0; bus.last = '0;
        step();

        // Drop: owner 1 withdraws after two writes; rotation resumes at 2.
        do_reset();
        bus.req = 4'b0010; set_lane(1, 8'h21);
        step();
        check("drop_gnt", 32'(bus.gnt), 32'h2);
        step();
        check("drop_w1", 32'(bus.shared_q), 32'h21);
        set_lane(1, 8'h22);
        step();
        check("drop_w2", 32'(bus.shared_q), 32'h22);
        bus.req = '0;
        step();
        check("drop_pulse", 32'(bus.wr_pulse), 32'h0);
        check("drop_data",  32'(bus.shared_q), 32'h22);
        check("drop_rel",   32'(bus.gnt),      32'h0);
        bus.req = 4'b0111; bus.last = 4'b0111;
        step();
        check("drop_ptr_gnt",   32'(bus.gnt),   32'h4);
        check("drop_ptr_owner", 32'(bus.owner), 32'd2);
        bus.req = '0; bus.last = '0;
        step();
        step();

        // Reset in the middle of a burst, before the second write's edge.
        do_reset();
        bus.req = 4'b0001; set_lane(0, 8'h31);
        step();
        step();
        check("mid_w1", 32'(bus.shared_q), 32'h31);
        set_lane(0, 8'h32);
        #3 rst_n = 1'b0;
        #1;
        check("mid_data",  32'(bus.shared_q), 32'h00);
        check("mid_gnt",   32'(bus.gnt),      32'h0);
        check("mid_busy",  32'(bus.busy),     32'h0);
        check("mid_pulse", 32'(bus.wr_pulse), 32'h0);
        step();
        check("mid_hold", 32'(bus.shared_q), 32'h00);
        bus.req = 4'b1000; bus.last = 4'b1000; set_lane(3, 8'h3C);
        #2 rst_n = 1'b1;
        step();
        check("mid_after_gnt",   32'(bus.gnt),   32'h8);
        check("mid_after_owner", 32'(bus.owner), 32'd3);
        step();
        check("mid_after_data", 32'(bus.shared_q), 32'h3C);
        bus.req = '0; bus.last = '0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
